// File: rtl/sram_resp_pkg.sv
// Shared constants for the SRAM / config-register responder: config region
// base, register offsets, decode width, read-source select type and a
// byte-lane merge helper.
package sram_resp_pkg;

  localparam int          CONF_DEC_W        = 16;
  localparam logic [15:0] CONF_BASE_DEFAULT = 16'hbfaf;

  localparam logic [15:0] OFF_LED    = 16'hf000;
  localparam logic [15:0] OFF_SWITCH = 16'hf004;
  localparam logic [15:0] OFF_TIMER  = 16'hf008;
  localparam logic [15:0] OFF_NUM    = 16'hf00c;

  typedef enum logic {
    SRC_RAM  = 1'b0,
    SRC_CONF = 1'b1
  } rd_src_e;

  // Replace the bytes of old_val selected by be with the matching bytes of new_val.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_resp_ram.sv
// Single-port 2^AW x 32 RAM with per-byte write enables and a registered
// read port. Contents are never reset. The read register only updates on a
// read, so it holds its value across idle and write cycles.
module sram_resp_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  // Byte-lane writes when any enable is set, otherwise a registered read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (|we) begin
        for (int i = 0; i < 4; i++) begin
          if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sram_confreg_resp.sv
// Data-SRAM responder: accesses whose upper address half matches CONF_BASE
// hit a small config-register block (LED, switch, free-running timer,
// display number); everything else goes to an internal RAM. Read data is
// registered and appears one cycle after the request.
module sram_confreg_resp
  import sram_resp_pkg::*;
#(
  parameter int                    RAM_AW    = 10,
  parameter logic [CONF_DEC_W-1:0] CONF_BASE = CONF_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out
);

  logic                  conf_sel;
  logic [CONF_DEC_W-1:0] conf_off;
  logic                  rd_req;
  logic                  wr_req;
  logic                  conf_wr;
  logic                  ram_en;
  logic [31:0]           ram_rdata;
  logic [31:0]           conf_rd_val;

  logic [15:0] led_q;
  logic [31:0] num_q;
  logic [31:0] timer_q;
  logic [7:0]  sw_meta_q;
  logic [7:0]  sw_sync_q;

  logic        rd_valid_q;
  rd_src_e     rd_src_q;
  logic [31:0] conf_rdata_q;

  logic unused_addr_bits;

  assign unused_addr_bits = ^data_sram_addr[1:0];

  assign conf_sel = (data_sram_addr[31 -: CONF_DEC_W] == CONF_BASE);
  assign conf_off = data_sram_addr[CONF_DEC_W-1:0];
  assign rd_req   = data_sram_en && (data_sram_wen == 4'h0);
  assign wr_req   = data_sram_en && (data_sram_wen != 4'h0);
  assign conf_wr  = wr_req && conf_sel;
  // Accesses presented while reset is held are dropped, RAM included.
  assign ram_en   = data_sram_en && !conf_sel && resetn;

  sram_resp_ram #(
    .AW(RAM_AW)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (data_sram_wen),
    .addr (data_sram_addr[RAM_AW+1:2]),
    .wdata(data_sram_wdata),
    .rdata(ram_rdata)
  );

  // Two-flop synchroniser for the asynchronous switch levels.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_meta_q <= 8'h0;
      sw_sync_q <= 8'h0;
    end else begin
      sw_meta_q <= switch_in;
      sw_sync_q <= sw_meta_q;
    end
  end

  // LED and display-number registers, byte-lane writable; LED keeps lanes 0-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q <= 16'h0;
      num_q <= 32'h0;
    end else if (conf_wr) begin
      if (conf_off == OFF_LED) begin
        if (data_sram_wen[0]) led_q[7:0]  <= data_sram_wdata[7:0];
        if (data_sram_wen[1]) led_q[15:8] <= data_sram_wdata[15:8];
      end
      if (conf_off == OFF_NUM) begin
        num_q <= byte_merge(num_q, data_sram_wdata, data_sram_wen);
      end
    end
  end

  // Free-running timer; a write patches the pre-increment value and skips that tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q <= 32'h0;
    end else if (conf_wr && (conf_off == OFF_TIMER)) begin
      timer_q <= byte_merge(timer_q, data_sram_wdata, data_sram_wen);
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  // Config read mux on the current (pre-edge) register values.
  always_comb begin
    conf_rd_val = 32'h0;
    case (conf_off)
      OFF_LED:    conf_rd_val = {16'h0, led_q};
      OFF_SWITCH: conf_rd_val = {24'h0, sw_sync_q};
      OFF_TIMER:  conf_rd_val = timer_q;
      OFF_NUM:    conf_rd_val = num_q;
      default:    conf_rd_val = 32'h0;
    endcase
  end

  // Capture the read source and config data so the output mux is steered next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid_q   <= 1'b0;
      rd_src_q     <= SRC_RAM;
      conf_rdata_q <= 32'h0;
    end else if (rd_req) begin
      rd_valid_q <= 1'b1;
      rd_src_q   <= conf_sel ? SRC_CONF : SRC_RAM;
      if (conf_sel) conf_rdata_q <= conf_rd_val;
    end
  end

  // Output mux; zero until the first read after reset so stale RAM output never leaks.
  always_comb begin
    data_sram_rdata = 32'h0;
    if (rd_valid_q) begin
      data_sram_rdata = (rd_src_q == SRC_CONF) ? conf_rdata_q : ram_rdata;
    end
  end

  assign led_out = led_q;
  assign num_out = num_q;

endmodule
